// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
   localparam int XLEN   = 32;
   localparam int PC_INC = 4;

   typedef logic [XLEN-1:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small instruction FIFO: DEPTH entries of type T, head-of-queue read, flush resets pointers.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fetch_entry_t,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  T              din_i,
   output T              head_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop_i) rd_q <= rd_q + 1'b1;
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: pc register, 1-cycle memory response tracking, credit-based issue
// into an instruction FIFO, redirect flush. Optional same-cycle bypass under FETCH_BYPASS_EN.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int              XLEN     = fetch_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_adr,
   input  logic [XLEN-1:0] mem_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } entry_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;

   entry_t          head, din;
   logic [CW-1:0]   count;
   logic            empty, full;
   logic            pop, issue, fifo_push, fifo_pop;
   logic [CW:0]     occ;

   assign din = '{pc: inflight_pc_q, inst: mem_data};

`ifdef FETCH_BYPASS_EN
   logic bypass;
   assign bypass     = empty & inflight_q;
   assign inst_valid = (~empty | inflight_q) & ~redirect_valid;
   assign inst_data  = bypass ? mem_data : head.inst;
   assign inst_pc    = bypass ? inflight_pc_q : head.pc;
   // A bypassed response that is consumed this cycle never enters the FIFO.
   assign fifo_push  = inflight_q & ~(bypass & pop);
   assign fifo_pop   = pop & ~bypass;
`else
   assign inst_valid = ~empty & ~redirect_valid;
   assign inst_data  = head.inst;
   assign inst_pc    = head.pc;
   assign fifo_push  = inflight_q;
   assign fifo_pop   = pop;
`endif

   assign pop = inst_valid & inst_ready;

   // Slots committed after this cycle: buffered plus in flight minus the one leaving.
   assign occ   = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign issue = rst_n & ~redirect_valid & (occ < (CW+1)'(DEPTH));

   assign mem_req = issue;
   assign mem_adr = pc_q;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc & ~XLEN'(3);
      end else if (issue) begin
         pc_d          = pc_q + XLEN'(PC_INC);
         inflight_d    = 1'b1;
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // Credit accounting must never let a response land in a full FIFO.
   always_ff @(posedge clk) begin
      if (rst_n && !redirect_valid && fifo_push && !fifo_pop) assert (!full);
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (redirect_valid),
      .din_i   (din),
      .head_o  (head),
      .count_o (count),
      .empty_o (empty),
      .full_o  (full)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized ready/redirect traffic
// checked against an in-order PC stream model.
module tb_fetch_stage;

`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0, rst_n = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req, inst_valid, mem_req2, inst_valid2;
   logic [31:0] mem_adr, mem_data, inst_data, inst_pc;
   logic [31:0] mem_adr2, mem_data2, inst_data2, inst_pc2;

   int          n_chk = 0, n_pass = 0;
   logic [31:0] exp_pc = '0;

   always #5 clk = ~clk;

   // Memory image: word i holds 0x1000 + i.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'h1000 + (a >> 2);
   endfunction

   always @(posedge clk) begin
      mem_data  <= word_at(mem_adr);
      mem_data2 <= word_at(mem_adr2);
   end

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_adr(mem_adr), .mem_data(mem_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc));

   fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req(mem_req2), .mem_adr(mem_adr2), .mem_data(mem_data2),
      .inst_valid(inst_valid2), .inst_ready(inst_ready), .inst_data(inst_data2), .inst_pc(inst_pc2));

   // Stream model: every accepted instruction is the next sequential PC since the last reset/redirect.
   always @(negedge clk) begin
      if (!rst_n) exp_pc = 32'h0;
      else begin
         if (redirect_valid) begin
            n_chk++;
            if (inst_valid !== 1'b0 || mem_req !== 1'b0)
               $display("FAIL redirect_mask valid=%b req=%b want 0/0", inst_valid, mem_req);
            else n_pass++;
         end
         if (inst_valid && inst_ready) begin
            n_chk++;
            if (inst_pc !== exp_pc || inst_data !== word_at(exp_pc))
               $display("FAIL stream pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp_pc, word_at(exp_pc));
            else n_pass++;
            exp_pc = exp_pc + 32'd4;
         end
         if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0 || mem_adr !== 32'h0)
         $display("FAIL reset_state req=%b vld=%b data=%h pc=%h adr=%h want 0/0/0/0/0", mem_req, inst_valid, inst_data, inst_pc, mem_adr);
      else n_pass++;
      n_chk++;
      if (mem_adr2 !== 32'hFFFF_FFFC) $display("FAIL reset_adr_wrap got %h want fffffffc", mem_adr2);
      else n_pass++;
      cyc();
   endtask

   task automatic test_stream();
      do_reset();
      inst_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         n_chk++;
         if (mem_req !== 1'b1) $display("FAIL stream_req cycle %0d got %b want 1", c, mem_req);
         else n_pass++;
         n_chk++;
         if (c < LAT) begin
            if (inst_valid !== 1'b0) $display("FAIL stream_latency cycle %0d valid=%b want 0", c, inst_valid);
            else n_pass++;
         end else if (inst_valid !== 1'b1 || inst_pc !== 32'(4*(c-LAT)) || inst_data !== 32'(32'h1000 + c - LAT))
            $display("FAIL stream_seq cycle %0d vld=%b pc=%h data=%h want 1/%h/%h", c, inst_valid, inst_pc, inst_data, 4*(c-LAT), 32'h1000 + c - LAT);
         else n_pass++;
         cyc();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 9) begin
            n_chk++;
            if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0)
               $display("FAIL bp_full req=%b vld=%b pc=%h want 0/1/0", mem_req, inst_valid, inst_pc);
            else n_pass++;
         end
         cyc();
      end
      inst_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_chk++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'(4*k))
            $display("FAIL bp_drain step %0d vld=%b pc=%h want 1/%h", k, inst_valid, inst_pc, 4*k);
         else n_pass++;
         cyc();
      end
   endtask

   task automatic test_redirect_flush();
      logic found;
      do_reset();
      cyc(); cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      cyc();
      redirect_valid = 1'b0; inst_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (inst_valid) found = 1'b1;
         else cyc();
      end
      n_chk++;
      if (!found || inst_pc !== 32'h40 || inst_data !== 32'h1010)
         $display("FAIL flush_first found=%b pc=%h data=%h want 1/40/1010", found, inst_pc, inst_data);
      else n_pass++;
      cyc();
   endtask

   task automatic test_redirect_b2b();
      logic found;
      inst_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h43;
      cyc();
      redirect_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (mem_adr !== 32'h40 || mem_req !== 1'b1) $display("FAIL align adr=%h req=%b want 40/1", mem_adr, mem_req);
      else n_pass++;
      cyc();
      for (int t = 1; t <= 3; t++) begin
         redirect_valid = 1'b1; redirect_pc = 32'(t * 16);
         cyc();
      end
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (inst_valid) found = 1'b1;
         else cyc();
      end
      n_chk++;
      if (!found || inst_pc !== 32'h30) $display("FAIL b2b_first found=%b pc=%h want 1/30", found, inst_pc);
      else n_pass++;
      cyc();
   endtask

   task automatic test_wrap();
      do_reset();
      inst_ready = 1'b1;
      for (int c = 0; c < LAT + 2; c++) begin
         @(negedge clk);
         if (c == LAT) begin
            n_chk++;
            if (inst_valid2 !== 1'b1 || inst_pc2 !== 32'hFFFF_FFFC || inst_data2 !== word_at(32'hFFFF_FFFC))
               $display("FAIL wrap_first vld=%b pc=%h data=%h want 1/fffffffc/%h", inst_valid2, inst_pc2, inst_data2, word_at(32'hFFFF_FFFC));
            else n_pass++;
         end
         if (c == LAT + 1) begin
            n_chk++;
            if (inst_valid2 !== 1'b1 || inst_pc2 !== 32'h0 || inst_data2 !== 32'h1000)
               $display("FAIL wrap_second vld=%b pc=%h data=%h want 1/0/1000", inst_valid2, inst_pc2, inst_data2);
            else n_pass++;
         end
         cyc();
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int c = 0; c < 5; c++) cyc();
      @(negedge clk);
      n_chk++;
      if (inst_valid !== 1'b1) $display("FAIL mid_prefill vld=%b want 1", inst_valid);
      else n_pass++;
      cyc();
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (inst_valid !== 1'b0 || mem_req !== 1'b0 || mem_adr !== 32'h0 || inst_pc !== 32'h0)
         $display("FAIL mid_reset vld=%b req=%b adr=%h pc=%h want 0/0/0/0", inst_valid, mem_req, mem_adr, inst_pc);
      else n_pass++;
      cyc(); cyc();
      rst_n = 1'b1; inst_ready = 1'b1;
      for (int c = 0; c <= LAT; c++) begin
         @(negedge clk);
         n_chk++;
         if (c < LAT && inst_valid !== 1'b0) $display("FAIL mid_relatency cycle %0d vld=%b want 0", c, inst_valid);
         else if (c == LAT && (inst_valid !== 1'b1 || inst_pc !== 32'h0))
            $display("FAIL mid_refetch vld=%b pc=%h want 1/0", inst_valid, inst_pc);
         else n_pass++;
         cyc();
      end
   endtask

   task automatic test_random();
      logic        p_hold;
      logic [31:0] p_pc, p_data;
      int          n_acc;
      p_hold = 1'b0; p_pc = '0; p_data = '0; n_acc = 0;
      for (int i = 0; i < 400; i++) begin
         inst_ready     = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = 32'($urandom_range(0, 255));
         @(negedge clk);
         if (p_hold && !redirect_valid) begin
            n_chk++;
            if (inst_valid !== 1'b1 || inst_pc !== p_pc || inst_data !== p_data)
               $display("FAIL rand_stable vld=%b pc=%h data=%h want 1/%h/%h", inst_valid, inst_pc, inst_data, p_pc, p_data);
            else n_pass++;
         end
         p_hold = inst_valid & ~inst_ready & ~redirect_valid;
         p_pc   = inst_pc;
         p_data = inst_data;
         if (inst_valid && inst_ready) n_acc++;
         cyc();
      end
      redirect_valid = 1'b0;
      n_chk++;
      if (n_acc < 100) $display("FAIL rand_progress accepted %0d want >= 100", n_acc);
      else n_pass++;
   endtask

   initial begin
      cyc();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_flush();
      test_redirect_b2b();
      test_wrap();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
